// File: rtl/alarm_setter.sv
// rtl/alarm_setter.sv - alarm time setter: button conditioning, RUN/SET_HR/SET_MIN edit FSM, commit
// Optional feature macro: ALARM_SETTER_AUTOREPEAT_EN (auto-repeat of held inc/dec in set states).
module alarm_setter #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1000000,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_RATE     = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic [4:0] alarm_hours,
    output logic [5:0] alarm_minutes,
    output logic       alarm_ena,
    output logic [5:0] edit_value,
    output logic [1:0] mode
);
    localparam int BM = 0;
    localparam int BI = 1;
    localparam int BD = 2;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {RUN = 2'b00, SET_HR = 2'b01, SET_MIN = 2'b10} state_t;

    logic [2:0]    btn_raw, sync1_q, sync2_q, deb_q, deb_prev_q, press;
    logic [DW-1:0] deb_cnt_q [3];

    assign btn_raw = {btn_dec, btn_inc, btn_mode};

    // Debounced level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_q[i]     <= sync2_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press = deb_q & ~deb_prev_q;

    state_t        state_q, state_d;
    logic [4:0]    hours_q, hours_d, hr_sh_q, hr_sh_d;
    logic [5:0]    minutes_q, minutes_d, min_sh_q, min_sh_d;
    logic          armed_q, armed_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          inc_rep, dec_rep, inc_ev, dec_ev, step_up, step_dn, any_ev, timeout;

`ifdef ALARM_SETTER_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_phase_q, rep_phase_d, rep_fire, held_alone;

    // rep_cnt_q counts held cycles since the press pulse; phase 1 = steady repeat rate.
    always_comb begin
        held_alone  = (state_q != RUN) && (deb_q[BI] ^ deb_q[BD]);
        rep_cnt_d   = rep_cnt_q;
        rep_phase_d = rep_phase_q;
        rep_fire    = 1'b0;
        if (!held_alone) begin
            rep_cnt_d   = '0;
            rep_phase_d = 1'b0;
        end else if (!rep_phase_q && rep_cnt_q == RW'(REPEAT_DELAY)) begin
            rep_fire    = 1'b1;
            rep_cnt_d   = RW'(1);
            rep_phase_d = 1'b1;
        end else if (rep_phase_q && rep_cnt_q == RW'(REPEAT_RATE)) begin
            rep_fire  = 1'b1;
            rep_cnt_d = RW'(1);
        end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
        end
    end

    assign inc_rep = rep_fire & deb_q[BI];
    assign dec_rep = rep_fire & deb_q[BD];
`else
    assign inc_rep = 1'b0;
    assign dec_rep = 1'b0;
`endif

    assign inc_ev  = press[BI] | inc_rep;
    assign dec_ev  = press[BD] | dec_rep;
    assign step_up = inc_ev & ~dec_ev & ~press[BM];
    assign step_dn = dec_ev & ~inc_ev & ~press[BM];
    assign any_ev  = (|press) | inc_rep | dec_rep;
    assign timeout = (state_q != RUN) && !any_ev && (idle_q == IW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (press[BM]) state_d = SET_HR;
            SET_HR:  if (press[BM]) state_d = SET_MIN; else if (timeout) state_d = RUN;
            SET_MIN: if (press[BM] || timeout) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        mode       = state_q;
        alarm_ena  = 1'b0;
        edit_value = '0;
        case (state_q)
            RUN:     alarm_ena  = armed_q;
            SET_HR:  edit_value = {1'b0, hr_sh_q};
            SET_MIN: edit_value = min_sh_q;
            default: ;
        endcase
    end

    always_comb begin
        hours_d   = hours_q;
        minutes_d = minutes_q;
        hr_sh_d   = hr_sh_q;
        min_sh_d  = min_sh_q;
        armed_d   = armed_q;
        case (state_q)
            RUN: begin
                if (press[BM]) begin
                    hr_sh_d  = hours_q;
                    min_sh_d = minutes_q;
                end else if (step_up) begin
                    armed_d = ~armed_q;
                end else if (step_dn) begin
                    armed_d = 1'b0;
                end
            end
            SET_HR: begin
                if (step_up)      hr_sh_d = (hr_sh_q == 5'd23) ? 5'd0 : hr_sh_q + 5'd1;
                else if (step_dn) hr_sh_d = (hr_sh_q == 5'd0) ? 5'd23 : hr_sh_q - 5'd1;
            end
            SET_MIN: begin
                if (press[BM]) begin
                    hours_d   = hr_sh_q;
                    minutes_d = min_sh_q;
                end else if (step_up) begin
                    min_sh_d = (min_sh_q == 6'd59) ? 6'd0 : min_sh_q + 6'd1;
                end else if (step_dn) begin
                    min_sh_d = (min_sh_q == 6'd0) ? 6'd59 : min_sh_q - 6'd1;
                end
            end
            default: ;
        endcase
        idle_d = (state_q == RUN || any_ev || timeout) ? '0 : idle_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hours_q   <= '0;
            minutes_q <= '0;
            hr_sh_q   <= '0;
            min_sh_q  <= '0;
            armed_q   <= 1'b0;
            idle_q    <= '0;
        end else begin
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            hr_sh_q   <= hr_sh_d;
            min_sh_q  <= min_sh_d;
            armed_q   <= armed_d;
            idle_q    <= idle_d;
        end
    end

    assign alarm_hours   = hours_q;
    assign alarm_minutes = minutes_q;
endmodule

// File: tb/tb_alarm_setter.sv
// tb/tb_alarm_setter.sv - scoreboard bench for alarm_setter with directed button vectors
module tb_alarm_setter;
    localparam int SEL_MODE = 0;
    localparam int SEL_HR   = 1;
    localparam int SEL_MIN  = 2;
    localparam int SEL_ENA  = 3;
    localparam int SEL_EDIT = 4;
    localparam int MB = 1;
    localparam int IB = 2;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic       alarm_ena;
    logic [5:0] edit_value;
    logic [1:0] mode;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int k;
    int hold_exp;

    typedef struct {
        string name;
        int    sel;
        int    val;
        int    due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   mon_a;

    alarm_setter #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (200),
        .REPEAT_DELAY   (40),
        .REPEAT_RATE    (10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_mode     (btn_mode),
        .btn_inc      (btn_inc),
        .btn_dec      (btn_dec),
        .alarm_hours  (alarm_hours),
        .alarm_minutes(alarm_minutes),
        .alarm_ena    (alarm_ena),
        .edit_value   (edit_value),
        .mode         (mode)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int actual(input int sel);
        case (sel)
            SEL_MODE: return int'(mode);
            SEL_HR:   return int'(alarm_hours);
            SEL_MIN:  return int'(alarm_minutes);
            SEL_ENA:  return int'(alarm_ena);
            default:  return int'(edit_value);
        endcase
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            mon_e = exp_q.pop_front();
            mon_a = actual(mon_e.sel);
            checks++;
            if (mon_a != mon_e.val) begin
                failures++;
                $display("FAIL %s actual=%0d expected=%0d cycle=%0d", mon_e.name, mon_a, mon_e.val, cyc);
            end
        end
    end

    task automatic chk(input string name, input int sel, input int val, input int dly);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        e.due  = cyc + dly;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int mask, input int v);
        if ((mask & MB) != 0) btn_mode = v[0];
        if ((mask & IB) != 0) btn_inc  = v[0];
        if ((mask & DB) != 0) btn_dec  = v[0];
    endtask

    // Raw high for `hold` cycles, then low long enough for the debounced release.
    task automatic press(input int mask, input int hold);
        drive(mask, 1);
        tick(hold);
        drive(mask, 0);
        tick(10);
    endtask

    initial begin
        tick(5);
        chk("rst_mode", SEL_MODE, 0, 0);
        chk("rst_hours", SEL_HR, 0, 0);
        chk("rst_minutes", SEL_MIN, 0, 0);
        chk("rst_ena", SEL_ENA, 0, 0);
        chk("rst_edit", SEL_EDIT, 0, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        press(IB, 8);
        chk("run_inc_arms", SEL_ENA, 1, 0);
        press(MB, 8);
        chk("set_hr_mode", SEL_MODE, 1, 0);
        chk("ena_off_editing", SEL_ENA, 0, 0);
        chk("hr_shadow_load", SEL_EDIT, 0, 0);
        for (int i = 0; i < 7; i++) press(IB, 8);
        chk("hr_inc7", SEL_EDIT, 7, 0);
        press(MB, 8);
        chk("set_min_mode", SEL_MODE, 2, 0);
        chk("min_shadow_load", SEL_EDIT, 0, 0);
        press(DB, 8);
        chk("min_wrap_down", SEL_EDIT, 59, 0);
        k = cyc;
        chk("commit_not_early", SEL_MODE, 2, 6);
        chk("commit_mode", SEL_MODE, 0, 7);
        chk("commit_hours", SEL_HR, 7, 7);
        chk("commit_minutes", SEL_MIN, 59, 7);
        chk("ena_back_in_run", SEL_ENA, 1, 7);
        press(MB, 8);

        press(MB, 8);
        chk("reload_hours", SEL_EDIT, 7, 0);
        for (int i = 0; i < 7; i++) press(DB, 8);
        chk("hr_dec7", SEL_EDIT, 0, 0);
        press(DB, 8);
        chk("hr_wrap_down", SEL_EDIT, 23, 0);
        press(IB, 8);
        chk("hr_wrap_up", SEL_EDIT, 0, 0);
        press(MB, 8);
        chk("reload_minutes", SEL_EDIT, 59, 0);
        press(IB, 8);
        chk("min_wrap_up", SEL_EDIT, 0, 0);
        press(DB, 8);
        chk("min_wrap_down2", SEL_EDIT, 59, 0);
        press(MB, 8);
        chk("commit2_hours", SEL_HR, 0, 0);
        chk("commit2_minutes", SEL_MIN, 59, 0);

        press(MB, 8);
        press(IB, 3);
        chk("glitch3_ignored", SEL_EDIT, 0, 0);
        press(IB, 6);
        chk("held6_one_step", SEL_EDIT, 1, 0);
        press(IB | DB, 8);
        chk("inc_dec_cancel", SEL_EDIT, 1, 0);
        press(MB | IB, 8);
        chk("mode_wins_mode", SEL_MODE, 2, 0);
        chk("mode_wins_edit", SEL_EDIT, 59, 0);
        press(MB, 8);
        chk("commit3_hours", SEL_HR, 1, 0);

        press(MB, 8);
        for (int i = 0; i < 3; i++) press(IB, 8);
        chk("pre_timeout_edit", SEL_EDIT, 4, 0);
        tick(150);
        chk("before_timeout", SEL_MODE, 1, 0);
        tick(50);
        chk("timeout_mode", SEL_MODE, 0, 0);
        chk("timeout_no_commit", SEL_HR, 1, 0);
        chk("timeout_edit_zero", SEL_EDIT, 0, 0);

        press(MB, 8);
        press(MB, 8);
        press(IB, 8);
        chk("rep_start_min", SEL_EDIT, 0, 0);
`ifdef ALARM_SETTER_AUTOREPEAT_EN
        hold_exp = 4;
`else
        hold_exp = 1;
`endif
        press(IB, 70);
        chk("hold70_steps", SEL_EDIT, hold_exp, 0);

        btn_inc = 1'b1;
        rst_n   = 1'b0;
        tick(5);
        chk("midedit_rst_mode", SEL_MODE, 0, 0);
        chk("midedit_rst_hours", SEL_HR, 0, 0);
        chk("midedit_rst_minutes", SEL_MIN, 0, 0);
        chk("midedit_rst_edit", SEL_EDIT, 0, 0);
        chk("midedit_rst_ena", SEL_ENA, 0, 0);
        tick(1);
        rst_n = 1'b1;
        chk("held_rst_no_early", SEL_ENA, 0, 3);
        chk("held_rst_press", SEL_ENA, 1, 12);
        tick(20);
        btn_inc = 1'b0;
        tick(10);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick(1);
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
